// File: rtl/multiword_alu_seq_pkg.sv
// multiword_alu_seq_pkg: shared ALU slice types, command codes and sequencer state.
package multiword_alu_seq_pkg;

    localparam int ALU_W = 4;

    typedef logic [ALU_W-1:0] AluVal;

    typedef enum logic [2:0] {
        CMD_ADD,
        CMD_SUB,
        CMD_COMP,
        CMD_RSHFT,
        CMD_XOR,
        CMD_XNOR,
        CMD_AND,
        CMD_OR
    } AluCmd;

    typedef struct packed {
        logic b_inv;
        logic carry_in;
        logic carry_disable;
    } AluFlags;

    typedef struct packed {
        AluCmd   cmd;
        AluFlags ctrl;
    } AluCtrl;

    typedef struct packed {
        AluCtrl ctrl;
        AluVal  d1;
        AluVal  d2;
    } AluArgs;

    typedef struct packed {
        AluVal res;
        logic  carry_out;
    } AluRet;

    typedef enum logic [1:0] {IDLE, RUN, DONE} MwSeqState;

    // Right shift moves bits toward the LSB, so its carry chain runs from the top slice down.
    function automatic logic slice_is_msw_first(input AluCmd cmd);
        return cmd == CMD_RSHFT;
    endfunction

    function automatic logic cmd_is_logic(input AluCmd cmd);
        return cmd inside {CMD_XOR, CMD_XNOR, CMD_AND, CMD_OR};
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational single-slice ALU with carry in/out.
module alu
    import multiword_alu_seq_pkg::*;
(
    input  AluArgs args,
    output AluRet  ret
);

    AluVal            b;
    logic             cin;
    logic [ALU_W:0]   sum;

    always_comb begin
        b   = args.ctrl.ctrl.b_inv ? ~args.d2 : args.d2;
        cin = args.ctrl.ctrl.carry_disable ? 1'b0 : args.ctrl.ctrl.carry_in;
        sum = {1'b0, args.d1} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
        ret = '0;
        case (args.ctrl.cmd)
            CMD_ADD, CMD_SUB, CMD_COMP: {ret.carry_out, ret.res} = sum;
            CMD_RSHFT: begin
                ret.res       = {cin, args.d2[ALU_W-1:1]};
                ret.carry_out = args.d2[0];
            end
            CMD_XOR:  ret.res = args.d1 ^ b;
            CMD_XNOR: ret.res = ~(args.d1 ^ b);
            CMD_AND:  ret.res = args.d1 & b;
            CMD_OR:   ret.res = args.d1 | b;
            default:  ret = '0;
        endcase
    end

endmodule

// File: rtl/check_if_0xF.sv
// check_if_0xF: flags an ALU slice value that is all ones.
module check_if_0xF
    import multiword_alu_seq_pkg::*;
(
    input  AluVal val,
    output logic  is_0xf
);

    assign is_0xf = &val;

endmodule

// File: rtl/multiword_alu_seq.sv
// multiword_alu_seq: issues a WORDS-slice operation to one alu, one slice per cycle, chaining carry.
// Define MULTIWORD_ALU_ALLONES_EN to add the rsp_all_ones result flag.
module multiword_alu_seq
    import multiword_alu_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  AluCtrl                 req_ctrl,
    input  logic [WORDS*ALU_W-1:0] req_d1,
    input  logic [WORDS*ALU_W-1:0] req_d2,
    output AluArgs                 alu_args,
    input  AluRet                  alu_ret,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORDS*ALU_W-1:0] rsp_res,
    output logic                   rsp_carry,
    output logic                   rsp_zero
`ifdef MULTIWORD_ALU_ALLONES_EN
    ,
    output logic                   rsp_all_ones
`endif
);

    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;

    MwSeqState         state_q, state_d;
    AluCtrl            ctrl_q, ctrl_d;
    AluVal [WORDS-1:0] d1_q, d1_d, d2_q, d2_d, res_q, res_d;
    logic [IW-1:0]     idx_q, idx_d, pos;
    logic              ready_q, ready_d, carry_q, carry_d, zero_q, zero_d;
    logic              accept, last;

    assign accept = state_q == IDLE && req_valid && ready_q;
    assign last   = idx_q == IW'(WORDS - 1);
    assign pos    = slice_is_msw_first(ctrl_q.cmd) ? IW'(WORDS - 1) - idx_q : idx_q;

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        ctrl_d   = ctrl_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        idx_d    = idx_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        alu_args = '0;
        case (state_q)
            IDLE: begin
                ready_d = !accept;
                if (accept) begin
                    state_d = RUN;
                    ctrl_d  = req_ctrl;
                    d1_d    = req_d1;
                    d2_d    = req_d2;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    carry_d = req_ctrl.ctrl.carry_in;
                end
            end
            RUN: begin
                alu_args.ctrl               = ctrl_q;
                // Logic ops never chain: every slice sees the originally requested carry_in.
                alu_args.ctrl.ctrl.carry_in = cmd_is_logic(ctrl_q.cmd) ? ctrl_q.ctrl.carry_in : carry_q;
                alu_args.d1                 = d1_q[pos];
                alu_args.d2                 = d2_q[pos];
                res_d[pos]                  = alu_ret.res;
                carry_d                     = alu_ret.carry_out;
                zero_d                      = zero_q & (alu_ret.res == '0);
                idx_d                       = idx_q + IW'(1);
                state_d                     = last ? DONE : RUN;
            end
            DONE: begin
                state_d = rsp_ready ? IDLE : DONE;
                ready_d = rsp_ready;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            ctrl_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ctrl_q  <= ctrl_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = state_q == DONE;
    assign rsp_res   = res_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;

`ifdef MULTIWORD_ALU_ALLONES_EN
    logic ones_q, ones_d, slice_ones;

    check_if_0xF u_chk (
        .val    (alu_ret.res),
        .is_0xf (slice_ones)
    );

    always_comb ones_d = accept ? 1'b1 : (state_q == RUN ? ones_q & slice_ones : ones_q);

    always_ff @(posedge clk) begin
        if (!rst_n) ones_q <= 1'b0;
        else        ones_q <= ones_d;
    end

    assign rsp_all_ones = ones_q;
`endif

endmodule

// File: tb/tb_multiword_alu_seq.sv
// tb_multiword_alu_seq: directed vectors for multiword_alu_seq driving an alu slice.
module tb_multiword_alu_seq;
    import multiword_alu_seq_pkg::*;

    localparam int WORDS = 4;

    logic                   clk = 1'b0;
    logic                   rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
    logic                   rsp_carry, rsp_zero;
    AluCtrl                 req_ctrl;
    logic [WORDS*ALU_W-1:0] req_d1, req_d2, rsp_res;
    AluArgs                 alu_args;
    AluRet                  alu_ret;
`ifdef MULTIWORD_ALU_ALLONES_EN
    logic                   rsp_all_ones;
`endif

    int    n_chk = 0;
    int    n_err = 0;
    AluVal seen [4];

    always #5 clk = ~clk;

    multiword_alu_seq #(.WORDS(WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ctrl     (req_ctrl),
        .req_d1       (req_d1),
        .req_d2       (req_d2),
        .alu_args     (alu_args),
        .alu_ret      (alu_ret),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res      (rsp_res),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero)
`ifdef MULTIWORD_ALU_ALLONES_EN
        ,
        .rsp_all_ones (rsp_all_ones)
`endif
    );

    alu u_alu (
        .args (alu_args),
        .ret  (alu_ret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic AluCtrl mk(input AluCmd c, input logic bi, input logic ci);
        AluCtrl r;
        r                    = '0;
        r.cmd                = c;
        r.ctrl.b_inv         = bi;
        r.ctrl.carry_in      = ci;
        r.ctrl.carry_disable = 1'b0;
        return r;
    endfunction

    task automatic do_op(input string tag, input AluCtrl c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic exp_c, input logic exp_z);
        int k;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_ctrl  = c;
        req_d1    = a;
        req_d2    = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            if (k < 4) seen[k] = alu_args.d2;
            @(posedge clk);
            #1 k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'd4);
        chk({tag, "_res"}, 32'(rsp_res), 32'(exp_res));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(exp_c));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp_z));
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_ctrl  = '0;
        req_d1    = '0;
        req_d2    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_res", 32'(rsp_res), 32'd0);
        chk("rst_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
        chk("rst_args", 32'(alu_args), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

        do_op("add_carry", mk(CMD_ADD, 1'b0, 1'b0), 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
        chk("add_lsw_first", 32'({seen[3], seen[2], seen[1], seen[0]}), 32'h0001);
        release_rsp("add_carry");

        do_op("add_wrap", mk(CMD_ADD, 1'b0, 1'b0), 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        release_rsp("add_wrap");

        do_op("sub_pos", mk(CMD_SUB, 1'b1, 1'b1), 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);
        release_rsp("sub_pos");
        do_op("sub_neg", mk(CMD_SUB, 1'b1, 1'b1), 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
        release_rsp("sub_neg");

        do_op("rshft0", mk(CMD_RSHFT, 1'b0, 1'b0), 16'h0000, 16'h0010, 16'h0008, 1'b0, 1'b0);
        chk("rshft_msw_first", 32'({seen[0], seen[1], seen[2], seen[3]}), 32'h0010);
        release_rsp("rshft0");
        do_op("rshft1", mk(CMD_RSHFT, 1'b0, 1'b1), 16'h0000, 16'h0010, 16'h8008, 1'b0, 1'b0);
        release_rsp("rshft1");

        do_op("xor_nochain", mk(CMD_XOR, 1'b0, 1'b1), 16'hA5F0, 16'h0FF0, 16'hAA00, 1'b0, 1'b0);
        release_rsp("xor_nochain");

        do_op("eq", mk(CMD_ADD, 1'b1, 1'b0), 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0);
`ifdef MULTIWORD_ALU_ALLONES_EN
        chk("eq_all_ones", 32'(rsp_all_ones), 32'd1);
`endif
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_res", 32'({rsp_res, rsp_carry, rsp_zero}), 32'({16'hFFFF, 1'b0, 1'b0}));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        release_rsp("eq");

        req_ctrl  = mk(CMD_ADD, 1'b0, 1'b0);
        req_d1    = 16'h0FFF;
        req_d2    = 16'h0001;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_args", 32'(alu_args), 32'd0);
        chk("mid_rst_outs", 32'({rsp_res, rsp_carry, rsp_zero}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 chk("mid_rst_novalid", 32'(rsp_valid), 32'd0);
        end
        do_op("after_rst", mk(CMD_ADD, 1'b0, 1'b0), 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
        release_rsp("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
